// File: rtl/base_tenc_pipe.sv
// Two-stage pipelined thermometer-to-binary encoder with valid/ready flow control.
// Reports the first-zero index of each beat and flags/counts bubbled (malformed) vectors.
module base_tenc_pipe #(
    parameter int dec_width = 8,
    parameter int enc_width = 4,
    parameter int cnt_width = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_v,
    output logic                   i_r,
    input  logic [0:dec_width-1]   i_d,
    output logic                   o_v,
    input  logic                   o_r,
    output logic [0:enc_width-1]   o_d,
    output logic                   o_err,
    output logic [cnt_width-1:0]   o_err_cnt
);

    generate
        if ((2 ** enc_width) <= dec_width) begin : g_bad_enc_width
            $error("base_tenc_pipe: enc_width too small to hold dec_width");
        end
    endgenerate

    logic                  s1_v;
    logic [0:dec_width-1]  s1_d;
    logic                  s2_v;
    logic [0:enc_width-1]  s2_d;
    logic                  s2_err;
    logic [cnt_width-1:0]  err_cnt;

    logic                  s1_adv;
    logic                  s2_adv;
    logic [0:enc_width-1]  enc_val;
    logic                  enc_err;
    logic                  seen_zero;

    // Each stage may take a new beat if it is empty or the stage downstream drains.
    assign s2_adv = ~s2_v | o_r;
    assign s1_adv = ~s1_v | s2_adv;
    assign i_r    = s1_adv;

    assign o_v       = s2_v;
    assign o_d       = s2_d;
    assign o_err     = s2_err;
    assign o_err_cnt = err_cnt;

    // Value is the first-zero index; any set bit beyond that index is a bubble.
    always_comb begin
        enc_val   = enc_width'(dec_width);
        enc_err   = 1'b0;
        seen_zero = 1'b0;
        for (int i = 0; i < dec_width; i++) begin
            if (seen_zero && s1_d[i]) begin
                enc_err = 1'b1;
            end
            if (!s1_d[i] && !seen_zero) begin
                enc_val   = enc_width'(i);
                seen_zero = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v <= 1'b0;
            s1_d <= '0;
        end else if (i_v && s1_adv) begin
            s1_v <= 1'b1;
            s1_d <= i_d;
        end else if (s1_adv) begin
            s1_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_v   <= 1'b0;
            s2_d   <= '0;
            s2_err <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_d   <= enc_val;
                s2_err <= enc_err;
            end
        end
    end

    // Saturating count of malformed beats moving from S1 into S2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (s2_adv && s1_v && enc_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_base_tenc_pipe.sv
// Self-checking bench for base_tenc_pipe (dec_width=7, enc_width=3, cnt_width=2).
// Directed steps followed by a randomized stream checked against a queue-based model.
module tb_base_tenc_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_v;
    logic        i_r;
    logic [0:6]  i_d;
    logic        o_v;
    logic        o_r;
    logic [0:2]  o_d;
    logic        o_err;
    logic [1:0]  o_err_cnt;

    typedef struct {
        int val;
        bit err;
        int cum;
    } beat_t;

    beat_t model_q[$];
    int    err_total = 0;
    int    accepted  = 0;
    int    checks    = 0;
    int    failures  = 0;

    always #5 clk = ~clk;

    base_tenc_pipe #(
        .dec_width(7),
        .enc_width(3),
        .cnt_width(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_v       (i_v),
        .i_r       (i_r),
        .i_d       (i_d),
        .o_v       (o_v),
        .o_r       (o_r),
        .o_d       (o_d),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
    );

    // Thermometer value = length of the unbroken run of ones starting at bit 0.
    function automatic int therm_val(input logic [0:6] d);
        int n = 0;
        while (n < 7 && d[n]) n++;
        return n;
    endfunction

    // Legal only if every set bit belongs to that leading run.
    function automatic bit therm_err(input logic [0:6] d);
        return $countones(d) != therm_val(d);
    endfunction

    function automatic logic [0:6] rand_vec();
        logic [0:6] d;
        int n;
        if ($urandom_range(0, 1) == 0) begin
            d = '0;
            n = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) d[i] = 1'b1;
        end else begin
            d = 7'($urandom);
        end
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check everything the model can predict, then clock it.
    task automatic applyStimulus(input logic v, input logic [0:6] d, input logic r);
        beat_t b;
        int    exp_cnt;
        i_v = v;
        i_d = d;
        o_r = r;
        #1;
        checkOutput("i_r", 32'(i_r), (model_q.size() == 2 && !r) ? 32'd0 : 32'd1);
        if (model_q.size() == 0) checkOutput("o_v_empty", 32'(o_v), 32'd0);
        if (model_q.size() == 2) checkOutput("o_v_full", 32'(o_v), 32'd1);
        if (o_v && model_q.size() > 0) begin
            exp_cnt = (model_q[0].cum > 3) ? 3 : model_q[0].cum;
            checkOutput("o_d", 32'(o_d), 32'(model_q[0].val));
            checkOutput("o_err", 32'(o_err), 32'(model_q[0].err));
            checkOutput("o_err_cnt", 32'(o_err_cnt), 32'(exp_cnt));
            if (o_r) void'(model_q.pop_front());
        end
        if (i_v && i_r) begin
            b.val = therm_val(d);
            b.err = therm_err(d);
            if (b.err) err_total++;
            b.cum = err_total;
            model_q.push_back(b);
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && model_q.size() > 0; k++) applyStimulus(1'b0, 7'b0, 1'b1);
        checkOutput("drain_left", 32'(model_q.size()), 32'd0);
        checkOutput("drain_o_v", 32'(o_v), 32'd0);
    endtask

    // Reset asserted away from the clock edge; outputs must clear without a clock.
    task automatic pulseReset();
        reset_n = 1'b0;
        #1;
        checkOutput("rst_o_v", 32'(o_v), 32'd0);
        checkOutput("rst_o_d", 32'(o_d), 32'd0);
        checkOutput("rst_o_err", 32'(o_err), 32'd0);
        checkOutput("rst_cnt", 32'(o_err_cnt), 32'd0);
        model_q.delete();
        err_total = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [0:6] mal [5];
        logic [0:6] stall_v [4];
        int         cnt_exp [5];
        int         cyc;

        mal     = '{7'b0100000, 7'b1010000, 7'b0010001, 7'b1111101, 7'b0000001};
        stall_v = '{7'b1000000, 7'b1100000, 7'b1110000, 7'b1111000};
        cnt_exp = '{1, 2, 3, 3, 3};

        reset_n = 1'b0;
        i_v     = 1'b0;
        i_d     = '0;
        o_r     = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_o_v", 32'(o_v), 32'd0);
        checkOutput("reset_cnt", 32'(o_err_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Back-to-back legal codes, two-cycle latency.
        applyStimulus(1'b1, 7'b1110000, 1'b1);
        checkOutput("lat_t1_o_v", 32'(o_v), 32'd0);
        applyStimulus(1'b1, 7'b0000000, 1'b1);
        checkOutput("lat_t2_o_v", 32'(o_v), 32'd1);
        checkOutput("lat_t2_o_d", 32'(o_d), 32'd3);
        applyStimulus(1'b1, 7'b1111111, 1'b1);
        checkOutput("b2b_o_d0", 32'(o_d), 32'd0);
        applyStimulus(1'b0, 7'b0, 1'b1);
        checkOutput("b2b_o_d7", 32'(o_d), 32'd7);
        checkOutput("b2b_o_err", 32'(o_err), 32'd0);
        drain();

        // Single bubbled vector.
        applyStimulus(1'b1, 7'b1101000, 1'b1);
        applyStimulus(1'b0, 7'b0, 1'b1);
        checkOutput("bubble_o_d", 32'(o_d), 32'd2);
        checkOutput("bubble_o_err", 32'(o_err), 32'd1);
        checkOutput("bubble_cnt", 32'(o_err_cnt), 32'd1);
        drain();

        // Fill both stages, then reset mid-flight.
        applyStimulus(1'b1, 7'b1000000, 1'b0);
        applyStimulus(1'b1, 7'b1100000, 1'b0);
        checkOutput("prereset_o_v", 32'(o_v), 32'd1);
        pulseReset();

        // First accept on the first edge after release; counter saturates at 3.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(k < 5, (k < 5) ? mal[k % 5] : 7'b0, 1'b1);
            if (k >= 1) checkOutput("sat_cnt", 32'(o_err_cnt), 32'(cnt_exp[k - 1]));
        end
        drain();
        checkOutput("sat_final", 32'(o_err_cnt), 32'd3);

        // Four stalled cycles during a 1,2,3,4 stream.
        applyStimulus(1'b1, stall_v[0], 1'b0);
        applyStimulus(1'b1, stall_v[1], 1'b0);
        applyStimulus(1'b1, stall_v[2], 1'b0);
        checkOutput("stall_i_r", 32'(i_r), 32'd0);
        applyStimulus(1'b1, stall_v[2], 1'b0);
        checkOutput("stall_o_v", 32'(o_v), 32'd1);
        checkOutput("stall_o_d", 32'(o_d), 32'd1);
        applyStimulus(1'b1, stall_v[2], 1'b1);
        applyStimulus(1'b1, stall_v[3], 1'b1);
        drain();

        // Peak throughput with o_r held high.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, rand_vec(), 1'b1);
            if (k >= 1) checkOutput("tput_o_v", 32'(o_v), 32'd1);
        end
        drain();

        // Randomized valid/ready toggling.
        accepted = 0;
        cyc      = 0;
        while (accepted < 10000 && cyc < 60000) begin
            applyStimulus($urandom_range(0, 3) != 0, rand_vec(), $urandom_range(0, 3) != 0);
            cyc++;
        end
        checkOutput("rand_budget", 32'(accepted >= 10000), 32'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
